// File: rtl/gf_horner_regbank_pkg.sv
// Shared definitions for the GF(2^M) Horner register bank: op encodings and field defaults.
// Default field is GF(2^5) with x^5 = x^2 + 1.
package gf_horner_regbank_pkg;

  typedef enum logic [1:0] {
    GF_OP_CLR  = 2'b00,
    GF_OP_LOAD = 2'b01,
    GF_OP_MAC  = 2'b10,
    GF_OP_HOLD = 2'b11
  } gf_op_e;

  localparam int         GF_M_DEFAULT    = 5;
  localparam logic [4:0] GF_POLY_DEFAULT = 5'b00101;

endpackage

// File: rtl/gf_horner_regbank_mul.sv
// Combinational GF(2^M) multiplier, polynomial basis, reduced by x^M = POLY.
// Zero latency; no handshake.
module gf_mul_param #(
  parameter int           M    = 5,
  parameter logic [M-1:0] POLY = 5'b00101
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;

  // MSB-first interleaved multiply: double (with reduction), then conditionally add a.
  always_comb begin
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0);
      if (b[i]) acc = acc ^ a;
    end
    p = acc;
  end

endmodule

// File: rtl/gf_horner_regbank.sv
// NCH-channel GF(2^M) Horner evaluator with symbol counter, frame-done pulse and result snapshot.
// Latency 1 cycle per accepted op; no backpressure, in_valid=0 or HOLD freezes all state.
module gf_horner_regbank
  import gf_horner_regbank_pkg::*;
#(
  parameter int           M     = GF_M_DEFAULT,
  parameter logic [M-1:0] POLY  = M'(GF_POLY_DEFAULT),
  parameter int           NCH   = 4,
  parameter int           NSYM  = 31,
  parameter int           CNT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic [M-1:0]       datain,
  input  logic [NCH*M-1:0]   coef,
  output logic [NCH*M-1:0]   dataout,
  output logic [NCH*M-1:0]   result,
  output logic [CNT_W-1:0]   sym_count,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSYM - 1);

  logic [NCH-1:0][M-1:0] regs;
  logic [NCH-1:0][M-1:0] res_q;
  logic [NCH-1:0][M-1:0] coef_ch;
  logic [NCH-1:0][M-1:0] prod;
  logic [NCH-1:0][M-1:0] mac_val;

  assign coef_ch = coef;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gf_mul_param #(
      .M    (M),
      .POLY (POLY)
    ) u_mul (
      .a (regs[g]),
      .b (coef_ch[g]),
      .p (prod[g])
    );
  end

  always_comb begin
    mac_val = '0;
    for (int i = 0; i < NCH; i++) mac_val[i] = prod[i] ^ datain;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs      <= '0;
      res_q     <= '0;
      sym_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid) begin
        case (gf_op_e'(op))
          GF_OP_CLR: begin
            regs      <= '0;
            sym_count <= '0;
          end
          GF_OP_LOAD: begin
            regs      <= {NCH{datain}};
            sym_count <= CNT_W'(1);
          end
          GF_OP_MAC: begin
            // First symbol of a frame ignores the stale register contents.
            if (sym_count == '0) begin
              regs      <= {NCH{datain}};
              sym_count <= CNT_W'(1);
            end else if (sym_count == LAST) begin
              regs      <= mac_val;
              res_q     <= mac_val;
              sym_count <= '0;
              done      <= 1'b1;
            end else begin
              regs      <= mac_val;
              sym_count <= sym_count + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dataout = regs;
  assign result  = res_q;
  assign busy    = (sym_count != '0);

endmodule
